// File: rtl/uart_aes_pkg.sv
// Constants and types shared by the UART/AES frame controllers (Rx and Tx side).
package uart_aes_pkg;

    localparam int          BYTE_W     = 8;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_CRC_HI  = 3'd2,
        ST_CRC_LO  = 3'd3,
        ST_CHECK   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_frame_controller_if.sv
// Byte input and frame result bundle between the UART Rx side and the frame controller.
interface rx_frame_controller_if #(
    parameter int PAYLOAD_BYTES = 16
);
    import uart_aes_pkg::*;

    logic                              rx_valid;
    logic [BYTE_W-1:0]                 rx_data;
    logic                              rx_frame_err;
    logic [BYTE_W*PAYLOAD_BYTES-1:0]   frame_data;
    logic                              frame_valid;
    logic                              crc_err;
    logic                              timeout_err;
    logic                              line_err;
    logic                              busy;

    modport master (
        output rx_valid, rx_data, rx_frame_err,
        input  frame_data, frame_valid, crc_err, timeout_err, line_err, busy
    );

    modport slave (
        input  rx_valid, rx_data, rx_frame_err,
        output frame_data, frame_valid, crc_err, timeout_err, line_err, busy
    );

endinterface

// File: rtl/crc16_byte.sv
// Combinational CRC-16/CCITT-FALSE step: folds one byte (MSB first) into the running CRC.
module crc16_byte
    import uart_aes_pkg::*;
(
    input  logic [15:0]       crc_in,
    input  logic [BYTE_W-1:0] data_in,
    output logic [15:0]       crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {data_in, 8'h00};
        for (int i = 0; i < BYTE_W; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC16_POLY) : {c[14:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/rx_frame_controller.sv
// Assembles UART bytes into payload + CRC16 frames, verifies the CRC and
// publishes good payloads; aborts on line errors and inter-byte timeouts.
module rx_frame_controller
    import uart_aes_pkg::*;
#(
    parameter int PAYLOAD_BYTES  = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset_n,
    rx_frame_controller_if.slave bus
);

    localparam int DATA_W = BYTE_W * PAYLOAD_BYTES;
    localparam int CNT_W  = $clog2(PAYLOAD_BYTES + 1);
    localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BYTES - 1);

    rx_state_t          state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [15:0]        crc_reg, crc_next;
    logic [15:0]        rx_crc_reg, rx_crc_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic [DATA_W-1:0]  frame_data_reg, frame_data_next;
    logic               frame_valid_reg, frame_valid_next;
    logic               crc_err_reg, crc_err_next;
    logic               timeout_err_reg, timeout_err_next;
    logic               line_err_reg, line_err_next;
    logic               busy_reg, busy_next;

    logic [15:0]        crc_seed;
    logic [15:0]        crc_upd;
    logic [DATA_W-1:0]  shift_in;
    logic               gap_expired;
    logic               to_idle;

    // A byte taken in IDLE or CHECK opens a new frame, so its CRC starts fresh.
    assign crc_seed    = (state_reg == ST_PAYLOAD) ? crc_reg : CRC16_INIT;
    assign shift_in    = {shift_reg[DATA_W-BYTE_W-1:0], bus.rx_data};
    assign gap_expired = (gap_reg >= GAP_LAST);

    crc16_byte u_crc (
        .crc_in  (crc_seed),
        .data_in (bus.rx_data),
        .crc_out (crc_upd)
    );

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        gap_next         = gap_reg;
        crc_next         = crc_reg;
        rx_crc_next      = rx_crc_reg;
        shift_next       = shift_reg;
        frame_data_next  = frame_data_reg;
        frame_valid_next = 1'b0;
        crc_err_next     = 1'b0;
        timeout_err_next = 1'b0;
        line_err_next    = 1'b0;
        busy_next        = busy_reg;
        to_idle          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    shift_next = shift_in;
                    crc_next   = crc_upd;
                    cnt_next   = CNT_W'(1);
                    gap_next   = '0;
                    busy_next  = 1'b1;
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD, ST_CRC_HI, ST_CRC_LO: begin
                if (bus.rx_frame_err) begin
                    line_err_next = 1'b1;
                    to_idle       = 1'b1;
                end else if (bus.rx_valid) begin
                    gap_next = '0;
                    if (state_reg == ST_PAYLOAD) begin
                        shift_next = shift_in;
                        crc_next   = crc_upd;
                        cnt_next   = cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_LAST) state_next = ST_CRC_HI;
                    end else if (state_reg == ST_CRC_HI) begin
                        rx_crc_next[15:8] = bus.rx_data;
                        state_next        = ST_CRC_LO;
                    end else begin
                        rx_crc_next[7:0] = bus.rx_data;
                        state_next       = ST_CHECK;
                    end
                end else if (gap_expired) begin
                    timeout_err_next = 1'b1;
                    to_idle          = 1'b1;
                end else if (gap_reg != GAP_MAX) begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            ST_CHECK: begin
                if (bus.rx_frame_err) begin
                    line_err_next = 1'b1;
                    to_idle       = 1'b1;
                end else begin
                    if (crc_reg == rx_crc_reg) begin
                        frame_data_next  = shift_reg;
                        frame_valid_next = 1'b1;
                    end else begin
                        crc_err_next = 1'b1;
                    end
                    if (bus.rx_valid) begin
                        shift_next = shift_in;
                        crc_next   = crc_upd;
                        cnt_next   = CNT_W'(1);
                        gap_next   = '0;
                        state_next = ST_PAYLOAD;
                    end else begin
                        to_idle = 1'b1;
                    end
                end
            end
            default: to_idle = 1'b1;
        endcase

        if (to_idle) begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            crc_next   = CRC16_INIT;
            cnt_next   = '0;
            gap_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            gap_reg         <= '0;
            crc_reg         <= CRC16_INIT;
            rx_crc_reg      <= '0;
            shift_reg       <= '0;
            frame_data_reg  <= '0;
            frame_valid_reg <= 1'b0;
            crc_err_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            line_err_reg    <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            gap_reg         <= gap_next;
            crc_reg         <= crc_next;
            rx_crc_reg      <= rx_crc_next;
            shift_reg       <= shift_next;
            frame_data_reg  <= frame_data_next;
            frame_valid_reg <= frame_valid_next;
            crc_err_reg     <= crc_err_next;
            timeout_err_reg <= timeout_err_next;
            line_err_reg    <= line_err_next;
            busy_reg        <= busy_next;
        end
    end

    assign bus.frame_data  = frame_data_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.crc_err     = crc_err_reg;
    assign bus.timeout_err = timeout_err_reg;
    assign bus.line_err    = line_err_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Directed bench: a 9-byte instance and a 16-byte/short-timeout instance share one Rx byte stream.
module tb_rx_frame_controller;
    import uart_aes_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_frame_err = 1'b0;

    always #5 clk = ~clk;

    rx_frame_controller_if #(.PAYLOAD_BYTES(9))  if9 ();
    rx_frame_controller_if #(.PAYLOAD_BYTES(16)) if16 ();

    assign if9.rx_valid      = rx_valid;
    assign if9.rx_data       = rx_data;
    assign if9.rx_frame_err  = rx_frame_err;
    assign if16.rx_valid     = rx_valid;
    assign if16.rx_data      = rx_data;
    assign if16.rx_frame_err = rx_frame_err;

    rx_frame_controller #(.PAYLOAD_BYTES(9), .TIMEOUT_CYCLES(1000)) dut9 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if9.slave)
    );

    rx_frame_controller #(.PAYLOAD_BYTES(16), .TIMEOUT_CYCLES(50)) dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if16.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   msg [0:15];
    logic [15:0]  crc_b;
    logic [127:0] data_a, data_b;
    logic         early;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input int n);
        for (int i = 0; i < n; i++) send(msg[i]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Bit-serial reference CRC over msg[0..n-1].
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ msg[i][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    function automatic logic [127:0] pack_msg(input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[119:0], msg[i]};
        return v;
    endfunction

    task automatic load_digits();
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_frame_data9", if9.frame_data, 128'h0);
        check("rst_busy9", if9.busy, 1'b0);
        check("rst_pulses9", {if9.frame_valid, if9.crc_err, if9.timeout_err, if9.line_err}, 4'b0);
        check("rst_pulses16", {if16.frame_valid, if16.crc_err, if16.timeout_err, if16.line_err, if16.busy}, 5'b0);
        reset_n = 1'b1;
        tick();

        // 1: "123456789" + 29 B1 -> good frame two cycles after the last CRC byte
        load_digits();
        send_seq(9);
        check("t1_busy_mid", if9.busy, 1'b1);
        send(8'h29);
        send(8'hB1);
        check("t1_fv_t1", if9.frame_valid, 1'b0);
        tick();
        check("t1_fv_t2", if9.frame_valid, 1'b1);
        check("t1_data", if9.frame_data, 128'h313233343536373839);
        check("t1_errs", {if9.crc_err, if9.timeout_err, if9.line_err}, 3'b0);
        check("t1_busy_end", if9.busy, 1'b0);
        tick();
        check("t1_fv_pulse", if9.frame_valid, 1'b0);

        // 2: bad CRC low byte -> crc_err, frame_data held
        send_seq(9);
        send(8'h29);
        send(8'hB0);
        tick();
        check("t2_crc_err", if9.crc_err, 1'b1);
        check("t2_fv", if9.frame_valid, 1'b0);
        check("t2_data_held", if9.frame_data, 128'h313233343536373839);
        check("t2_busy", if9.busy, 1'b0);
        tick();
        check("t2_crc_err_pulse", if9.crc_err, 1'b0);

        // 3: P=16, timeout 50 cycles after the 5th byte, then a good frame
        do_reset();
        for (int i = 0; i < 5; i++) msg[i] = 8'hA0 + 8'(i);
        send_seq(5);
        early = 1'b0;
        for (int k = 1; k < 50; k++) begin
            tick();
            if (if16.timeout_err || !if16.busy) early = 1'b1;
        end
        check("t3_no_early_timeout", early, 1'b0);
        tick();
        check("t3_timeout", if16.timeout_err, 1'b1);
        check("t3_busy", if16.busy, 1'b0);
        tick();
        check("t3_timeout_pulse", if16.timeout_err, 1'b0);
        for (int i = 0; i < 16; i++) msg[i] = 8'(i * 17 + 3);
        crc_b  = crc_model(16);
        data_b = pack_msg(16);
        send_seq(16);
        send(crc_b[15:8]);
        send(crc_b[7:0]);
        tick();
        check("t3_fv", if16.frame_valid, 1'b1);
        check("t3_data", if16.frame_data, data_b);

        // 4: line error with byte 3 -> abort, byte dropped; alone in IDLE -> ignored
        do_reset();
        load_digits();
        send(8'h31);
        send(8'h32);
        rx_frame_err = 1'b1;
        rx_valid     = 1'b1;
        rx_data      = 8'h33;
        tick();
        rx_frame_err = 1'b0;
        rx_valid     = 1'b0;
        check("t4_line_err", if9.line_err, 1'b1);
        check("t4_busy", if9.busy, 1'b0);
        check("t4_data_untouched", if9.frame_data, 128'h0);
        tick();
        check("t4_line_err_pulse", if9.line_err, 1'b0);
        rx_frame_err = 1'b1;
        tick();
        rx_frame_err = 1'b0;
        check("t4_idle_ferr", {if9.line_err, if9.busy}, 2'b00);
        send_seq(9);
        send(8'h29);
        send(8'hB1);
        tick();
        check("t4_recover_fv", if9.frame_valid, 1'b1);
        check("t4_recover_data", if9.frame_data, 128'h313233343536373839);

        // 5: back-to-back, frame 2 starts on frame 1's CHECK cycle
        send_seq(9);
        send(8'h29);
        send(8'hB1);
        for (int i = 0; i < 9; i++) msg[i] = 8'h41 + 8'(i);
        crc_b  = crc_model(9);
        data_b = pack_msg(9);
        send(msg[0]);
        check("t5_fv_a", if9.frame_valid, 1'b1);
        check("t5_data_a", if9.frame_data, 128'h313233343536373839);
        check("t5_busy", if9.busy, 1'b1);
        send(msg[1]);
        check("t5_fv_a_pulse", if9.frame_valid, 1'b0);
        for (int i = 2; i < 9; i++) send(msg[i]);
        send(crc_b[15:8]);
        send(crc_b[7:0]);
        tick();
        check("t5_fv_b", if9.frame_valid, 1'b1);
        check("t5_data_b", if9.frame_data, data_b);
        check("t5_no_err", if9.crc_err, 1'b0);

        // 6: reset mid-payload clears outputs immediately
        send(msg[0]);
        send(msg[1]);
        send(msg[2]);
        send(msg[3]);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_busy", if9.busy, 1'b0);
        check("t6_data", if9.frame_data, 128'h0);
        check("t6_pulses", {if9.frame_valid, if9.crc_err, if9.timeout_err, if9.line_err}, 4'b0);
        tick();
        reset_n = 1'b1;
        tick();
        send_seq(9);
        send(crc_b[15:8]);
        send(crc_b[7:0]);
        tick();
        check("t6_fv", if9.frame_valid, 1'b1);
        check("t6_data_b", if9.frame_data, data_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
